// File: rtl/ntt_job_ctrl.sv
// ntt_job_ctrl -- job sequencer for the NTT core and its single-port BRAM.
//
// Purpose:
//   On an accepted host start, reads N words from BRAM into the core's input
//   buffer, waits for the BRAM pipeline to empty, launches the core, waits for
//   completion, then writes N results back to BRAM and pulses done.
//   While a job is active this block is the only BRAM master.
//
// Optional feature:
//   NTT_TIMEOUT_EN -- adds a compute watchdog. After TIMEOUT cycles in COMPUTE
//   without ntt_done, err is set and the job jumps to DONE with no writes.
//   When undefined, no counter is built and err is tied low.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   start             job request, sampled only in IDLE
//   src_base/dst_base word base indices, latched when a job is accepted
//   busy, done, err   host handshake (done is a one-cycle pulse, err is sticky)
//   bram_*            BRAM port; bram_addr is a byte address, bram_din = st_data
//   ld_valid/idx/data core input-buffer write port (ld_data is registered)
//   ntt_start         one-cycle launch pulse to the core
//   ntt_done          core completion level
//   st_idx/st_data    core output-buffer read port (st_data is combinational)
module ntt_job_ctrl #(
  parameter int N       = 64,
  parameter int DW      = 64,
  parameter int AW      = 12,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-4:0]        src_base,
  input  logic [AW-4:0]        dst_base,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [AW-1:0]        bram_addr,
  output logic                 bram_en,
  output logic                 bram_we,
  output logic [DW-1:0]        bram_din,
  input  logic [DW-1:0]        bram_dout,
  output logic                 ld_valid,
  output logic [$clog2(N)-1:0] ld_idx,
  output logic [DW-1:0]        ld_data,
  output logic                 ntt_start,
  input  logic                 ntt_done,
  output logic [$clog2(N)-1:0] st_idx,
  input  logic [DW-1:0]        st_data
);

  localparam int IW = $clog2(N);
  localparam int WW = AW - 3;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [2:0]    LAT_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_COMPUTE,
    S_STORE,
    S_DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [2:0]     lat_reg, lat_next;
  logic [WW-1:0]  src_reg, dst_reg;
  logic           busy_reg, done_reg, en_reg, we_reg, ntt_start_reg;
  logic           accept;
  logic           core_done_ok;
  logic           timeout_hit;
  logic           timeout_take;

  assign accept = (state_reg == S_IDLE) && start;

  // The launch cycle is the one flagged by ntt_start_reg; ntt_done is only
  // trusted from the following cycle, so a level left high by the previous
  // job cannot end this one early.
  assign core_done_ok = (state_reg == S_COMPUTE) && !ntt_start_reg && ntt_done;
  assign timeout_take = (state_reg == S_COMPUTE) && timeout_hit && !core_done_ok;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    lat_next   = lat_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          idx_next   = '0;
        end
      end
      S_LOAD: begin
        if (idx_reg == IDX_LAST) begin
          state_next = S_DRAIN;
          idx_next   = '0;
          lat_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      S_DRAIN: begin
        if (lat_reg == LAT_LAST) begin
          state_next = S_COMPUTE;
        end else begin
          lat_next = lat_reg + 3'd1;
        end
      end
      S_COMPUTE: begin
        if (core_done_ok) begin
          state_next = S_STORE;
          idx_next   = '0;
        end else if (timeout_take) begin
          state_next = S_DONE;
        end
      end
      S_STORE: begin
        if (idx_reg == IDX_LAST) begin
          state_next = S_DONE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      lat_reg       <= '0;
      src_reg       <= '0;
      dst_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      en_reg        <= 1'b0;
      we_reg        <= 1'b0;
      ntt_start_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      lat_reg       <= lat_next;
      if (accept) begin
        src_reg <= src_base;
        dst_reg <= dst_base;
      end
      busy_reg      <= (state_next != S_IDLE);
      done_reg      <= (state_next == S_DONE);
      en_reg        <= (state_next == S_LOAD) || (state_next == S_STORE);
      we_reg        <= (state_next == S_STORE);
      ntt_start_reg <= (state_next == S_COMPUTE) && (state_reg != S_COMPUTE);
    end
  end

  // ------------------------------------------------------ BRAM address
  logic [WW-1:0] word_base;
  logic [WW-1:0] word_idx;

  assign word_base = (state_reg == S_STORE) ? dst_reg : src_reg;
  // Word index wraps naturally in WW bits.
  assign word_idx  = word_base + WW'(idx_reg);
  assign bram_addr = en_reg ? {word_idx, 3'b000} : '0;
  assign bram_en   = en_reg;
  assign bram_we   = we_reg;
  assign bram_din  = st_data;

  // ---------------------------------------------------- read pipeline
  // One stage per cycle of BRAM latency, tracking which reads are in flight
  // and their slot index, so the load port sees data exactly when it lands.
  logic          rd_vld_pipe [RD_LAT];
  logic [IW-1:0] rd_idx_pipe [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_pipe[0] <= 1'b0;
      rd_idx_pipe[0] <= '0;
    end else begin
      rd_vld_pipe[0] <= (state_reg == S_LOAD);
      rd_idx_pipe[0] <= idx_reg;
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rd_pipe
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_vld_pipe[gi] <= 1'b0;
          rd_idx_pipe[gi] <= '0;
        end else begin
          rd_vld_pipe[gi] <= rd_vld_pipe[gi-1];
          rd_idx_pipe[gi] <= rd_idx_pipe[gi-1];
        end
      end
    end
  endgenerate

  logic          ld_valid_reg;
  logic [IW-1:0] ld_idx_reg;
  logic [DW-1:0] ld_data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_valid_reg <= 1'b0;
      ld_idx_reg   <= '0;
      ld_data_reg  <= '0;
    end else begin
      ld_valid_reg <= rd_vld_pipe[RD_LAT-1];
      if (rd_vld_pipe[RD_LAT-1]) begin
        ld_idx_reg  <= rd_idx_pipe[RD_LAT-1];
        ld_data_reg <= bram_dout;
      end
    end
  end

  assign ld_valid  = ld_valid_reg;
  assign ld_idx    = ld_idx_reg;
  assign ld_data   = ld_data_reg;
  assign st_idx    = idx_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign ntt_start = ntt_start_reg;

  // ---------------------------------------------------- watchdog
`ifdef NTT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cmp_cnt_reg;
  logic          err_reg;

  // The counter holds the number of COMPUTE cycles already completed.
  assign timeout_hit = (cmp_cnt_reg == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      cmp_cnt_reg <= (state_reg == S_COMPUTE) ? cmp_cnt_reg + 1'b1 : '0;
      if (accept) begin
        err_reg <= 1'b0;
      end else if (timeout_take) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_job_ctrl.sv
// Self-checking bench for ntt_job_ctrl: BRAM model with configurable read
// latency, a core model whose done delay is chosen per job, and a reference
// memory image that predicts every load slot and every BRAM write.
module tb_ntt_job_ctrl;
  localparam int N       = 64;
  localparam int DW      = 64;
  localparam int AW      = 12;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 100;
  localparam int IW      = $clog2(N);
  localparam int WW      = AW - 3;
  localparam int WORDS   = 1 << WW;
  localparam int LOG     = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] src_base = '0;
  logic [WW-1:0] dst_base = '0;
  logic          busy, done, err;
  logic [AW-1:0] bram_addr;
  logic          bram_en, bram_we;
  logic [DW-1:0] bram_din, bram_dout;
  logic          ld_valid;
  logic [IW-1:0] ld_idx;
  logic [DW-1:0] ld_data;
  logic          ntt_start;
  logic          ntt_done = 1'b0;
  logic [IW-1:0] st_idx;
  logic [DW-1:0] st_data;

  ntt_job_ctrl #(.N(N), .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .err(err), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
    .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data), .ntt_start(ntt_start),
    .ntt_done(ntt_done), .st_idx(st_idx), .st_data(st_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    return {32'(i) * 32'h0100_0193, 32'hDEAD_0000 | 32'(i)};
  endfunction

  function automatic logic [DW-1:0] core_val(input logic [31:0] key, input int j);
    return {key, 32'(j) * 32'h9E37_79B1};
  endfunction

  // ---------------- core model: output buffer and completion level
  logic [31:0] job_key = 32'h1234_5678;
  int          cur_c = 10;
  logic        force_done = 1'b0;
  assign st_data = core_val(job_key, int'(st_idx));

  // ---------------- BRAM model
  logic [DW-1:0] mem     [WORDS];
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic          mem_init = 1'b1;
  int            wr_n = 0;
  logic [AW-1:0] wr_log_addr [LOG];
  logic [DW-1:0] wr_log_data [LOG];

  assign bram_dout = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= init_val(i);
    end else if (bram_en && bram_we) begin
      mem[bram_addr[AW-1:3]] <= bram_din;
      wr_log_addr[wr_n] <= bram_addr;
      wr_log_data[wr_n] <= bram_din;
      wr_n <= wr_n + 1;
    end
    rd_pipe[0] <= mem[bram_addr[AW-1:3]];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  // ---------------- monitor (samples on the falling edge)
  int            ld_n = 0, ns_n = 0, done_n = 0;
  logic [IW-1:0] ld_log_idx  [LOG];
  logic [DW-1:0] ld_log_data [LOG];
  int            ld_log_cyc  [LOG];
  int            ns_log_cyc  [LOG];
  int            done_log_cyc [LOG];
  logic          done_log_err [LOG];
  logic          core_run = 1'b0;
  int            core_s = 0;

  always @(negedge clk) begin
    if (ld_valid) begin
      ld_log_idx[ld_n]  <= ld_idx;
      ld_log_data[ld_n] <= ld_data;
      ld_log_cyc[ld_n]  <= cyc;
      ld_n <= ld_n + 1;
    end
    if (ntt_start) begin
      ns_log_cyc[ns_n] <= cyc;
      ns_n <= ns_n + 1;
    end
    if (done) begin
      done_log_cyc[done_n] <= cyc;
      done_log_err[done_n] <= err;
      done_n <= done_n + 1;
    end
    // Core raises done during the C-th cycle counted from the launch cycle.
    if (!rst || done) begin
      core_run <= 1'b0;
      ntt_done <= force_done;
    end else begin
      if (ntt_start) begin
        core_run <= 1'b1;
        core_s   <= cyc;
      end
      ntt_done <= force_done || (core_run && (cyc >= core_s + cur_c - 1));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One job; checks timing, every load slot, the launch pulse and every write.
  task automatic run_job(input int src, input int dst, input int c, input int exp_len,
                         input bit hold, input bit expect_to);
    int ld0, wr0, dn0, ns0, acc, waited, n_ld, n_wr, n_exp;
    logic [31:0] key;
    ld0 = ld_n; wr0 = wr_n; dn0 = done_n; ns0 = ns_n;
    key = $urandom;
    job_key  = key;
    cur_c    = c;
    src_base = WW'(src);
    dst_base = WW'(dst);
    start    = 1'b1;
    acc      = cyc + 1;
    @(negedge clk); #1;
    if (!hold) start = 1'b0;
    chk("busy_first_cycle", 64'(busy), 64'd1);
    chk("err_clear_on_accept", 64'(err), 64'd0);
    waited = 0;
    while (done_n == dn0 && waited < 4000) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("done_seen", 64'(done_n - dn0), 64'd1);
    if (done_n == dn0) return;
    chk("job_length", 64'(done_log_cyc[dn0] - acc + 1), 64'(exp_len));
    chk("err_at_done", 64'(done_log_err[dn0]), 64'(expect_to));
    n_ld = ld_n - ld0;
    chk("ld_count", 64'(n_ld), 64'(N));
    for (int i = 0; i < n_ld && i < N; i++) begin
      chk($sformatf("ld_idx[%0d]", i), 64'(ld_log_idx[ld0+i]), 64'(i));
      chk($sformatf("ld_data[%0d]", i), ld_log_data[ld0+i], ref_mem[(src + i) % WORDS]);
      chk($sformatf("ld_cycle[%0d]", i), 64'(ld_log_cyc[ld0+i] - acc), 64'(RD_LAT + 1 + i));
    end
    chk("ntt_start_count", 64'(ns_n - ns0), 64'd1);
    if (ns_n > ns0) chk("ntt_start_cycle", 64'(ns_log_cyc[ns0] - acc), 64'(N + RD_LAT));
    n_wr  = wr_n - wr0;
    n_exp = expect_to ? 0 : N;
    chk("wr_count", 64'(n_wr), 64'(n_exp));
    for (int j = 0; j < n_wr && j < N; j++) begin
      chk($sformatf("wr_addr[%0d]", j), 64'(wr_log_addr[wr0+j]), 64'(((dst + j) % WORDS) * 8));
      chk($sformatf("wr_data[%0d]", j), wr_log_data[wr0+j], core_val(key, j));
    end
    for (int j = 0; j < n_exp; j++) ref_mem[(dst + j) % WORDS] = core_val(key, j);
    $display("job src=%0d dst=%0d C=%0d len=%0d loads=%0d writes=%0d err=%0b",
             src, dst, c, done_log_cyc[dn0] - acc + 1, n_ld, n_wr, done_log_err[dn0]);
    if (!hold) begin
      @(negedge clk); #1;
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("done_one_cycle", 64'(done), 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_bram_en"}, 64'(bram_en), 64'd0);
    chk({tag, "_bram_we"}, 64'(bram_we), 64'd0);
    chk({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
    chk({tag, "_ld_valid"}, 64'(ld_valid), 64'd0);
    chk({tag, "_ld_idx"}, 64'(ld_idx), 64'd0);
    chk({tag, "_ld_data"}, ld_data, 64'd0);
    chk({tag, "_ntt_start"}, 64'(ntt_start), 64'd0);
    chk({tag, "_st_idx"}, 64'(st_idx), 64'd0);
  endtask

  typedef struct {
    int src;
    int dst;
    int c;
    int exp_len;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   src, dst, c, wr0, waited;
    logic [31:0] key;

    vecs[0] = '{src: 0,   dst: 64,  c: 10, exp_len: 2*N + RD_LAT + 10 + 1};
    vecs[1] = '{src: 0,   dst: 500, c: 2,  exp_len: 2*N + RD_LAT + 2 + 1};
    vecs[2] = '{src: 480, dst: 100, c: 37, exp_len: 2*N + RD_LAT + 37 + 1};
    vecs[3] = '{src: 500, dst: 500, c: 5,  exp_len: 2*N + RD_LAT + 5 + 1};

    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);

    // Reset state
    @(negedge clk); #1;
    mem_init = 1'b0;
    @(negedge clk); #1;
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk); #1;

    // Table of basic jobs, including address wrap on both sides
    for (int v = 0; v < 4; v++)
      run_job(vecs[v].src, vecs[v].dst, vecs[v].c, vecs[v].exp_len, 1'b0, 1'b0);

    // start held high: next job only in the first IDLE cycle after DONE
    run_job(10, 200, 6, 2*N + RD_LAT + 6 + 1, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk("hold_idle_cycle_busy", 64'(busy), 64'd0);
    run_job(20, 300, 4, 2*N + RD_LAT + 4 + 1, 1'b0, 1'b0);

    // ntt_done already high at launch: ignored in the launch cycle
    force_done = 1'b1;
    run_job(33, 77, 1 << 30, 2*N + RD_LAT + 2 + 1, 1'b0, 1'b0);
    force_done = 1'b0;
    @(negedge clk); #1;

    // Reset during STORE write 20
    wr0 = wr_n;
    key = $urandom;
    job_key  = key;
    cur_c    = 5;
    src_base = WW'(7);
    dst_base = WW'(300);
    start    = 1'b1;
    @(negedge clk); #1;
    start  = 1'b0;
    waited = 0;
    while (wr_n - wr0 < 20 && waited < 1000) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("reset_reached_write20", 64'(wr_n - wr0), 64'd20);
    chk("reset_st_idx_before", 64'(st_idx), 64'd20);
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk); #1;
    chk("reset_no_more_writes", 64'(wr_n - wr0), 64'd20);
    rst = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (j < 20) ref_mem[(300 + j) % WORDS] = core_val(key, j);
      chk($sformatf("reset_mem[%0d]", j), mem[(300 + j) % WORDS], ref_mem[(300 + j) % WORDS]);
    end
    @(negedge clk); #1;
    run_job(300, 7, 8, 2*N + RD_LAT + 8 + 1, 1'b0, 1'b0);

`ifdef NTT_TIMEOUT_EN
    // Core never completes: watchdog ends the job with no writes
    run_job(5, 9, 1 << 30, N + RD_LAT + TIMEOUT + 1, 1'b0, 1'b1);
    chk("err_sticky", 64'(err), 64'd1);
    run_job(9, 5, 3, 2*N + RD_LAT + 3 + 1, 1'b0, 1'b0);
`else
    chk("err_tied_low", 64'(err), 64'd0);
`endif

    // Randomised jobs against the reference image
    for (int r = 0; r < 6; r++) begin
      src = int'($urandom_range(0, WORDS - 1));
      dst = int'($urandom_range(0, WORDS - 1));
      c   = int'($urandom_range(2, 25));
      run_job(src, dst, c, 2*N + RD_LAT + c + 1, 1'b0, 1'b0);
    end

    // Whole-memory compare against the reference image
    for (int i = 0; i < WORDS; i++) begin
      if (mem[i] !== ref_mem[i]) chk($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);
    end
    chk("final_mem_word0", mem[0], ref_mem[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ntt_job_ctrl.md
# ntt_job_ctrl

Job sequencer for the 64-point NTT core and its single-port BRAM. On a host `start` it streams N input words from BRAM into the core's input buffer, launches the transform, waits for completion, then writes N results back to BRAM. It is the only BRAM master while a job is active and presents a start/busy/done handshake to the host.

## Interface
Parameters:
- `N`, 64: points per transform (power of two, 2..256).
- `DW`, 64: data word width.
- `AW`, 12: BRAM byte-address width.
- `RD_LAT`, 1: BRAM read latency in cycles (1..4).
- `TIMEOUT`, 4096: compute watchdog limit in cycles (used only with `NTT_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: job request, sampled only in IDLE.
- `src_base` in AW-3: input word base index, latched on accept.
- `dst_base` in AW-3: output word base index, latched on accept.
- `busy` out 1: high from accept until DONE exits.
- `done` out 1: one-cycle pulse at job end.
- `err` out 1: sticky watchdog error; cleared on the next accepted start.
- `bram_addr` out AW: byte address, `((base+idx) mod 2^(AW-3)) << 3`.
- `bram_en` out 1: BRAM enable.
- `bram_we` out 1: BRAM write strobe.
- `bram_din` out DW: write data, equal to `st_data`.
- `bram_dout` in DW: read data.
- `ld_valid` out 1: `ld_data` is valid for core input slot `ld_idx`.
- `ld_idx` out log2(N): core input slot index.
- `ld_data` out DW: registered copy of `bram_dout`.
- `ntt_start` out 1: one-cycle launch pulse to the core.
- `ntt_done` in 1: core completion level.
- `st_idx` out log2(N): core output slot currently being read.
- `st_data` in DW: core output word at `st_idx`, combinational.

## Operation
- FSM states: IDLE → LOAD → DRAIN → COMPUTE → STORE → DONE → IDLE.
- **IDLE**
  - When `start`=1, latch both bases, clear `err`, go to LOAD.
  - `start` is ignored in every other state; no queueing.
- **LOAD**
  - N cycles with `bram_en`=1 and `bram_we`=0.
  - Read index i = 0..N-1, one per cycle, addressed from `src_base`.
- **DRAIN**
  - RD_LAT cycles, no new reads.
  - Read data for index i is returned as `ld_valid`/`ld_idx`=i/`ld_data` exactly RD_LAT+1 cycles after its address was issued. RD_LAT cycles come from the BRAM; the extra cycle is the `ld_data` register.
- **COMPUTE**
  - `ntt_start`=1 in the first COMPUTE cycle only.
  - `ntt_done` is ignored in that same first cycle; it is sampled from the next cycle on.
  - Exit to STORE on the first cycle `ntt_done` is sampled high.
- **STORE**
  - N cycles with `bram_en`=1 and `bram_we`=1.
  - Cycle j: `st_idx`=j, address taken from `dst_base`+j, `bram_din`=`st_data`.
- **DONE**
  - One cycle with `done`=1, then IDLE.
- Address arithmetic:
  - Base + index wraps modulo 2^(AW-3) words.
  - No range checking is performed.
- Reset:
  - Asynchronous; takes effect in any state.
  - The FSM returns to IDLE and all outputs go to 0: `busy`, `done`, `err`, `bram_en`, `bram_we`, `ld_valid`, `ntt_start`, and zeroed addresses, indices and data.
  - An in-flight job is abandoned; any partial writes already made to BRAM remain.

## Timing
- Accept edge = edge where `start`=1 is sampled in IDLE. `busy` is high from the cycle after that edge.
- Job length from the accept edge to the `done` pulse is N + RD_LAT + C + N + 1 cycles.
  - C = number of COMPUTE cycles, with C ≥ 2.
- `ld_valid` is asserted for N consecutive cycles. The first is cycle RD_LAT+2 after the accept edge.
- The earliest next job: `start` high during the DONE cycle is ignored. It is accepted in the first IDLE cycle after DONE.
- All outputs are registered except `bram_din` and `bram_addr`.
  - `bram_din` is a pass-through of `st_data`.
  - `bram_addr` is decoded from registered state and index.

## Configuration
- `NTT_TIMEOUT_EN` defined:
  - A COMPUTE cycle counter is added.
  - If TIMEOUT cycles elapse in COMPUTE without `ntt_done`, set `err`=1 and go directly to DONE, skipping STORE. No BRAM writes occur for that job.
- `NTT_TIMEOUT_EN` undefined:
  - No counter is built; COMPUTE waits indefinitely.
  - `err` is tied to 0.

## Test plan
- Basic job: N=64, RD_LAT=1, `src_base`=0, `dst_base`=64, core done after 10 cycles → slots 0..63 loaded from byte addresses 0x000..0x1F8; 64 writes to 0x200..0x3F8; `done` at cycle 64+1+10+64+1=140.
- RD_LAT=2: BRAM model with 2-cycle latency → `ld_idx`=0 carries word 0 at cycle 4; DRAIN lasts 2 cycles; no slot is missed or duplicated.
- Wrap: AW=12, `dst_base`=500 → writes 0..11 go to words 500..511, writes 12..63 go to words 0..51.
- `start` held high throughout → second job accepted in the first IDLE cycle after `done`; `ntt_start` pulses exactly once per job.
- Reset (`rst`=0) at STORE write 20 → all outputs 0 immediately; BRAM words 0..19 of the destination are written and 20..63 are untouched; a new `start` runs a full job.
- With `NTT_TIMEOUT_EN` and TIMEOUT=100, core never raises `ntt_done` → `err`=1 and `done` pulse after 100 COMPUTE cycles, zero writes; `err` clears on the next accepted start.
